cfg_pwm: RTL and testbench

Four-channel PWM generator that consumes the packed configuration bytes produced by the SPI register bank and returns one status byte to it. It sits directly downstream of the SPI wrapper's `config_regs` output and upstream of the pad drivers. Period and duty settings are double-buffered and take effect only at period boundaries, so SPI writes never cause glitched output pulses.

---
 rtl/cfg_pwm.sv | 141 ++++++++++++++
 tb/tb_cfg_pwm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_pwm.sv
// Four-channel PWM generator driven by packed SPI config bytes.
// Period/duty are shadowed and only reload at period wraps, so writes never glitch outputs.
module cfg_pwm #(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      ena,
  input  logic [NUM_REGS*WIDTH-1:0] config_regs,
  output logic [WIDTH-1:0]          status_regs,
  output logic [NUM_CH-1:0]         pwm_o,
  output logic                      wrap_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic             cfg_en, cfg_inv, cfg_oneshot, cfg_clr;
  logic [WIDTH-1:0] cfg_prescale, cfg_period;
  logic             unused_cfg;

  assign cfg_en       = config_regs[0];
  assign cfg_inv      = config_regs[1];
  assign cfg_oneshot  = config_regs[2];
  assign cfg_prescale = config_regs[1*WIDTH +: WIDTH];
  assign cfg_period   = config_regs[2*WIDTH +: WIDTH];
  assign cfg_clr      = config_regs[7*WIDTH];
  assign unused_cfg   = ^config_regs;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] duty_sh_q [NUM_CH];
  logic [WIDTH-1:0] duty_sh_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d, cmp;
  logic             wrap_q, wrap_d;
  logic             wrap_sticky_q, wrap_sticky_d;
  logic             done_sticky_q, done_sticky_d;
  logic             en_s_q, en_s_d;
  logic             clr_prev_q, clr_prev_d;
  logic             shadow_load, wrap_evt, clr_edge;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign duty_sh_d[gi] = shadow_load ? config_regs[(3+gi)*WIDTH +: WIDTH] : duty_sh_q[gi];
      assign cmp[gi]       = (cnt_q < duty_sh_q[gi]);
    end
  endgenerate

  assign clr_edge = cfg_clr & ~clr_prev_q;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    cnt_d       = cnt_q;
    shadow_load = 1'b0;
    wrap_evt    = 1'b0;
    pwm_d       = {NUM_CH{cfg_inv}};
    case (state_q)
      IDLE: begin
        pcnt_d      = '0;
        cnt_d       = '0;
        shadow_load = 1'b1;
        if (cfg_en) state_d = RUN;
      end
      RUN: begin
        pwm_d = cmp ^ {NUM_CH{cfg_inv}};
        if (!cfg_en) begin
          // Dropping EN abandons the period outright: no wrap, no sticky update.
          state_d = IDLE;
          pcnt_d  = '0;
          cnt_d   = '0;
        end else if (pcnt_q == cfg_prescale) begin
          pcnt_d = '0;
          if (cnt_q == period_sh_q) begin
            cnt_d       = '0;
            wrap_evt    = 1'b1;
            shadow_load = 1'b1;
            if (cfg_oneshot) state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      DONE: begin
        pcnt_d = '0;
        cnt_d  = '0;
        if (!cfg_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    period_sh_d   = shadow_load ? cfg_period : period_sh_q;
    wrap_d        = wrap_evt;
    // A set event in the same cycle as a clear edge takes priority.
    wrap_sticky_d = wrap_evt ? 1'b1 : (clr_edge ? 1'b0 : wrap_sticky_q);
    done_sticky_d = (wrap_evt && cfg_oneshot) ? 1'b1 : (clr_edge ? 1'b0 : done_sticky_q);
    en_s_d        = cfg_en;
    clr_prev_d    = cfg_clr;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      cnt_q         <= '0;
      period_sh_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= '0;
      pwm_q         <= '0;
      wrap_q        <= 1'b0;
      wrap_sticky_q <= 1'b0;
      done_sticky_q <= 1'b0;
      en_s_q        <= 1'b0;
      clr_prev_q    <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      cnt_q         <= cnt_d;
      period_sh_q   <= period_sh_d;
      for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= duty_sh_d[i];
      pwm_q         <= pwm_d;
      wrap_q        <= wrap_d;
      wrap_sticky_q <= wrap_sticky_d;
      done_sticky_q <= done_sticky_d;
      en_s_q        <= en_s_d;
      clr_prev_q    <= clr_prev_d;
    end
  end

  assign pwm_o       = pwm_q;
  assign wrap_o      = wrap_q;
  assign status_regs = {{(WIDTH-4){1'b0}}, en_s_q, done_sticky_q, wrap_sticky_q, (state_q == RUN)};

endmodule

// File: tb/tb_cfg_pwm.sv
// Directed bench for cfg_pwm: waveform traces, shadowing, oneshot, sticky clear, freeze, reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_cfg_pwm;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [63:0] config_regs;
  logic [7:0]  status_regs;
  logic [3:0]  pwm_o;
  logic        wrap_o;

  logic [7:0] ctrl_b, pre_b, per_b, clr_b;
  logic [7:0] d0_b, d1_b, d2_b, d3_b;

  assign config_regs = {clr_b, d3_b, d2_b, d1_b, d0_b, per_b, pre_b, ctrl_b};

  int checks = 0;
  int errors = 0;

  logic [31:0] tr_a, tr_b, tr_c, tr_w;
  logic [7:0]  st0;
  int          n;

  cfg_pwm #(.NUM_REGS(8), .WIDTH(8), .NUM_CH(4)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .config_regs (config_regs),
    .status_regs (status_regs),
    .pwm_o       (pwm_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1;
    ctrl_b = 8'h00; pre_b = 8'h00; per_b = 8'h00; clr_b = 8'h00;
    d0_b = 8'h00; d1_b = 8'h00; d2_b = 8'h00; d3_b = 8'h00;
    #1;
    check("rst_pwm", {28'd0, pwm_o}, 32'h0);
    check("rst_wrap", {31'd0, wrap_o}, 32'h0);
    check("rst_status", {24'd0, status_regs}, 32'h0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // PRESCALE=0 PERIOD=9 DUTY0=3: 3 high / 7 low, wrap every 10 clocks
    pre_b = 8'd0; per_b = 8'd9; d0_b = 8'd3; ctrl_b = 8'h01;
    tr_a = '0; tr_w = '0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      tr_a[j] = pwm_o[0];
      tr_w[j] = wrap_o;
      if (j == 0) st0 = status_regs;
    end
    check("t1_status_start", {24'd0, st0}, 32'h09);
    check("t1_pwm0_trace", tr_a, 32'h00E0380E);
    check("t1_wrap_trace", tr_w, 32'h00100400);
    check("t1_status_wrap", {24'd0, status_regs}, 32'h0B);

    // Mid-period DUTY0 3->7: current period keeps 3, next one uses 7
    d0_b = 8'd7;
    tr_a = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tr_a[k] = pwm_o[0];
    end
    check("t1_duty_shadow", tr_a, 32'h000E3F80);

    // Clean CLR edge clears WRAP
    clr_b = 8'h01;
    @(negedge clk);
    check("clr_clean", {24'd0, status_regs}, 32'h09);
    clr_b = 8'h00;
    repeat (5) @(negedge clk);
    // CLR edge coincident with a wrap: WRAP stays set
    clr_b = 8'h01;
    @(negedge clk);
    check("clr_wrap_wrapo", {31'd0, wrap_o}, 32'h1);
    check("clr_wrap_status", {24'd0, status_regs}, 32'h0B);

    clr_b = 8'h00; ctrl_b = 8'h00;
    repeat (2) @(negedge clk);
    check("en_drop_status", {24'd0, status_regs}, 32'h02);
    check("en_drop_pwm", {28'd0, pwm_o}, 32'h0);

    // PRESCALE=2 PERIOD=3: 12-clock period, DUTY1=2 -> 6 high, DUTY2=0 low, DUTY3=255 high
    pre_b = 8'd2; per_b = 8'd3; d0_b = 8'd0; d1_b = 8'd2; d2_b = 8'd0; d3_b = 8'd255;
    ctrl_b = 8'h01;
    tr_a = '0; tr_b = '0; tr_c = '0; tr_w = '0;
    for (int m = 0; m < 25; m++) begin
      @(negedge clk);
      tr_a[m] = pwm_o[1];
      tr_b[m] = pwm_o[2];
      tr_c[m] = pwm_o[3];
      tr_w[m] = wrap_o;
    end
    check("t2_pwm1_trace", tr_a, 32'h0007E07E);
    check("t2_pwm2_trace", tr_b, 32'h0);
    check("t2_pwm3_trace", tr_c, 32'h01FFFFFE);
    check("t2_wrap_trace", tr_w, 32'h01001000);

    // Freeze for 5 clocks: outputs hold, period stretches by 5
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    check("freeze_pwm", {28'd0, pwm_o}, 32'hA);
    check("freeze_wrap", {31'd0, wrap_o}, 32'h0);
    ena = 1'b1;
    n = 0;
    for (int w = 1; w <= 20; w++) begin
      @(negedge clk);
      if (wrap_o && n == 0) n = w;
    end
    check("freeze_stretch", n, 32'd10);

    // Back to idle with a CLR edge: status fully clear
    ctrl_b = 8'h00; clr_b = 8'h01;
    @(negedge clk);
    clr_b = 8'h00;
    @(negedge clk);
    check("idle_clr_status", {24'd0, status_regs}, 32'h00);

    // ONESHOT, PERIOD=4: a single wrap, then DONE
    pre_b = 8'd0; per_b = 8'd4; d0_b = 8'd2; d1_b = 8'd0; d2_b = 8'd0; d3_b = 8'd0;
    ctrl_b = 8'h05;
    tr_a = '0; tr_w = '0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      tr_a[m] = pwm_o[0];
      tr_w[m] = wrap_o;
    end
    check("os_pwm0_trace", tr_a, 32'h6);
    check("os_wrap_trace", tr_w, 32'h20);
    check("os_status", {24'd0, status_regs}, 32'h0E);
    check("os_pwm", {28'd0, pwm_o}, 32'h0);

    ctrl_b = 8'h04;
    @(negedge clk);
    ctrl_b = 8'h05;
    tr_w = '0;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      tr_w[m] = wrap_o;
    end
    check("os_restart_wrap", tr_w, 32'h20);
    check("os_restart_status", {24'd0, status_regs}, 32'h0E);
    clr_b = 8'h01;
    @(negedge clk);
    check("clr_done_status", {24'd0, status_regs}, 32'h08);
    clr_b = 8'h00;

    // INV in idle drives all outputs high
    ctrl_b = 8'h02;
    repeat (2) @(negedge clk);
    check("inv_idle_pwm", {28'd0, pwm_o}, 32'hF);
    check("inv_idle_status", {24'd0, status_regs}, 32'h00);

    // Asynchronous reset mid-run clears outputs without waiting for a clock
    ctrl_b = 8'h01; per_b = 8'd9; d0_b = 8'd5; d1_b = 8'd5; d2_b = 8'd5; d3_b = 8'd5;
    repeat (4) @(negedge clk);
    check("pre_rst_pwm", {28'd0, pwm_o}, 32'hF);
    #2 rstb = 1'b0;
    #1;
    check("async_rst_pwm", {28'd0, pwm_o}, 32'h0);
    check("async_rst_wrap", {31'd0, wrap_o}, 32'h0);
    check("async_rst_status", {24'd0, status_regs}, 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
